hpi_bus_controller: RTL and testbench
=====================================

// Module: hpi_bus_controller
// PURPOSE
// - Sequences and shares the CY7C67200 OTG HPI port (cs/addr/data/r/w) between two requesters:
//   requester 0 = NIOS-side HPI PIO bridge, requester 1 = hardware keycode poller.
// - Turns single-word read/write requests into timed HPI bus cycles: setup, strobe, hold, recovery.
// - Sits between the SoC PIO exports and the top-level OTG pins. Owns the HPI data bus tristate enable.
// PARAMETERS
// - SETUP_CYC   1  cycles with cs_n/addr/data valid before the r_n/w_n strobe (>=1)
// - STROBE_CYC  4  cycles r_n or w_n is held low (>=1)
// - HOLD_CYC    1  cycles cs_n/addr/data are held after the strobe rises (>=1)
// - FIXED_PRIO  0  0 = round-robin between requesters; 1 = requester 0 always wins
// PORTS
// - Clk          in   1   system clock
// - Reset        in   1   asynchronous active-high reset
// - req_i        in   2   per-requester request level; hold high until matching ack_o
// - we_i         in   2   per-requester 1 = write, 0 = read
// - addr_i       in   4   {addr1[1:0], addr0[1:0]} HPI register select
// - wdata_i      in   32  {wdata1[15:0], wdata0[15:0]} write data
// - ack_o        out  2   one-cycle completion pulse per requester
// - rdata_o      out  16  read data of the last completed read; valid with ack_o
// - busy_o       out  1   high from grant through the recovery state
// - hpi_cs_n     out  1   HPI chip select, active low
// - hpi_r_n      out  1   HPI read strobe, active low
// - hpi_w_n      out  1   HPI write strobe, active low
// - hpi_addr     out  2   HPI address
// - hpi_dout     out  16  data toward the chip
// - hpi_dout_en  out  1   tristate enable for hpi_dout; top level drives the pad
// - hpi_din      in   16  data from the chip
// BEHAVIOUR
// - Reset, async and immediate: cs_n=r_n=w_n=1, hpi_addr=0, hpi_dout=0, dout_en=0, ack_o=0,
//   rdata_o=0, busy_o=0, state=IDLE, rr pointer=0. Reset mid-cycle abandons the access; no ack.
// - States: IDLE -> SETUP -> STROBE -> HOLD -> RECOV -> IDLE. All outputs are registered.
// - IDLE: if any req_i is high, arbitrate. Latch the winner's id, we, addr and wdata; go to SETUP.
// - Arbitration, round-robin: on simultaneous requests the grant goes to the requester not granted last.
//   The pointer updates at grant only. FIXED_PRIO=1: requester 0 always wins.
// - SETUP: cs_n=0, addr valid. For a write, dout_en=1 and dout=wdata. Lasts SETUP_CYC cycles.
// - STROBE: r_n=0 for a read, or w_n=0 for a write. Lasts STROBE_CYC cycles.
//   - Reads: hpi_din is captured into rdata_o on the last STROBE cycle edge.
// - HOLD: strobes = 1; cs_n, addr and dout/dout_en unchanged. Lasts HOLD_CYC cycles.
// - RECOV: cs_n=1, dout_en=0, ack_o[id]=1 for exactly 1 cycle. Then IDLE.
//   Guarantees >=2 cycles of cs_n high between accesses.
// - Latency from grant edge to ack: 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (7 with defaults).
// - Request fields are sampled only at grant. Later changes do not affect the active access.
//   A req_i dropped before ack still completes and acks.
// - A requester must deassert req_i in the cycle after its ack, or a new access is granted.
// - r_n and w_n are never low together. dout_en=1 implies a write access with cs_n=0.
// - Phase counter width = $clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC)+1). Counter reloads on each state entry.
// - The non-granted requester waits with req_i high and no ack. There is no timeout.
// STRUCTURE
// - hpi_pkg: state enum (IDLE, SETUP, STROBE, HOLD, RECOV).
// - hpi_pkg: HPI address constants HPI_DATA=2'd0, HPI_MAILBOX=2'd1, HPI_ADDR=2'd2, HPI_STATUS=2'd3.
// - Sub-module hpi_rr_arbiter: 2-way round-robin/fixed arbiter, inputs req[1:0] and grant_en.
//   Outputs a one-hot grant and a registered last-grant pointer.
// - The top level instantiates the tristate: OTG_DATA = hpi_dout_en ? hpi_dout : 'z.
// TESTING
// - Single write, defaults: req0=1, we0=1, addr0=2, wdata0=16'h1234.
//   -> cs_n low 6 cycles, w_n low cycles 2-5 after grant, dout_en with dout=16'h1234,
//      ack_o=2'b01 7 cycles after grant.
// - Single read: req1=1, we1=0, addr1=0, hpi_din=16'hBEEF during strobe.
//   -> r_n low 4 cycles, w_n stays 1, dout_en stays 0, ack_o=2'b10 with rdata_o=16'hBEEF.
// - Contention: req_i=2'b11 held for 4 accesses.
//   -> grants alternate 0,1,0,1; FIXED_PRIO=1 grants 0,0,0,0. cs_n high >=2 cycles between accesses.
// - Field stability: change wdata0 to 16'hFFFF after grant.
//   -> bus still drives 16'h1234 for the whole access.
// - Reset mid-strobe: assert Reset in STROBE.
//   -> same cycle (async) cs_n=r_n=w_n=1, dout_en=0, no ack.
//   After release, a new req0 completes normally in 7 cycles.
// - Timing parameters SETUP=2, STROBE=1, HOLD=3: single write -> ack 7 cycles after grant;
//   w_n low exactly 1 cycle.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus controller.
package hpi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RECOV  = 3'd4
    } hpi_state_t;

    // HPI register select values driven on hpi_addr
    localparam logic [1:0] HPI_DATA    = 2'd0;
    localparam logic [1:0] HPI_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_ADDR    = 2'd2;
    localparam logic [1:0] HPI_STATUS  = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// Two-way arbiter for the HPI port: round-robin on ties, or requester 0 first when FIXED_PRIO=1.
module hpi_rr_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic       prio;  // requester favoured on the next tie
    logic [1:0] pick;

    always_comb begin
        pick = 2'b00;
        if (req[0] && (!req[1] || FIXED_PRIO != 0 || !prio))
            pick = 2'b01;
        else if (req[1])
            pick = 2'b10;
    end

    assign grant = grant_en ? pick : 2'b00;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prio       <= 1'b0;
            last_grant <= 1'b0;
        end else if (|grant) begin
            last_grant <= grant[1];
            prio       <= grant[0];
        end
    end

endmodule

// File: rtl/hpi_bus_controller.sv
// Shares the OTG HPI port between the NIOS PIO bridge (0) and the keycode poller (1), timing each
// access as setup/strobe/hold/recovery. The OTG_DATA pad is built from hpi_dout/hpi_dout_en upstream.
module hpi_bus_controller
    import hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [1:0]  ack_o,
    output logic [15:0] rdata_o,
    output logic        busy_o,
    output logic        hpi_cs_n,
    output logic        hpi_r_n,
    output logic        hpi_w_n,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_dout,
    output logic        hpi_dout_en,
    input  logic [15:0] hpi_din
);

    localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    hpi_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       grant;
    logic             active_id;

    logic        sel_we;
    logic [1:0]  sel_addr;
    logic [15:0] sel_wdata;

    hpi_rr_arbiter #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req_i),
        .grant_en   (state == IDLE),
        .grant      (grant),
        .last_grant (active_id)
    );

    assign sel_we    = grant[1] ? we_i[1]        : we_i[0];
    assign sel_addr  = grant[1] ? addr_i[3:2]    : addr_i[1:0];
    assign sel_wdata = grant[1] ? wdata_i[31:16] : wdata_i[15:0];

    // Each phase counts down from its load value; the state advances when the count reaches zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            ack_o       <= 2'b00;
            rdata_o     <= 16'h0000;
            busy_o      <= 1'b0;
            hpi_cs_n    <= 1'b1;
            hpi_r_n     <= 1'b1;
            hpi_w_n     <= 1'b1;
            hpi_addr    <= 2'b00;
            hpi_dout    <= 16'h0000;
            hpi_dout_en <= 1'b0;
        end else begin
            ack_o <= 2'b00;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        state    <= SETUP;
                        cnt      <= SETUP_LD;
                        busy_o   <= 1'b1;
                        hpi_cs_n <= 1'b0;
                        hpi_addr <= sel_addr;
                        we_q     <= sel_we;
                        if (sel_we) begin
                            hpi_dout    <= sel_wdata;
                            hpi_dout_en <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                        if (we_q)
                            hpi_w_n <= 1'b0;
                        else
                            hpi_r_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        hpi_r_n <= 1'b1;
                        hpi_w_n <= 1'b1;
                        if (!we_q)
                            rdata_o <= hpi_din;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state       <= RECOV;
                        hpi_cs_n    <= 1'b1;
                        hpi_dout_en <= 1'b0;
                        ack_o       <= active_id ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RECOV: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_strobe_excl: assert property (@(posedge Clk) disable iff (Reset) (hpi_r_n || hpi_w_n));
    a_dout_en_ok:  assert property (@(posedge Clk) disable iff (Reset) (!hpi_dout_en || (we_q && !hpi_cs_n)));

endmodule

// File: tb/tb_hpi_bus_controller.sv
// Directed bench: default timing (a), FIXED_PRIO=1 (b) and SETUP=2/STROBE=1/HOLD=3 (c) share stimulus.
module tb_hpi_bus_controller;
    import hpi_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  we_i = 2'b00;
    logic [3:0]  addr_i = 4'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [15:0] hpi_din = 16'h0;

    logic [1:0]  a_ack, b_ack, c_ack;
    logic [15:0] a_rdata, b_rdata, c_rdata;
    logic        a_busy, b_busy, c_busy;
    logic        a_cs_n, b_cs_n, c_cs_n;
    logic        a_r_n, b_r_n, c_r_n;
    logic        a_w_n, b_w_n, c_w_n;
    logic [1:0]  a_addr, b_addr, c_addr;
    logic [15:0] a_dout, b_dout, c_dout;
    logic        a_en, b_en, c_en;

    int vectors = 0;
    int errors  = 0;

    // {busy, cs_n, r_n, w_n, dout_en, ack[1:0]}
    logic [6:0] a_bus, b_bus, c_bus;
    assign a_bus = {a_busy, a_cs_n, a_r_n, a_w_n, a_en, a_ack};
    assign b_bus = {b_busy, b_cs_n, b_r_n, b_w_n, b_en, b_ack};
    assign c_bus = {c_busy, c_cs_n, c_r_n, c_w_n, c_en, c_ack};

    always #5 Clk = ~Clk;

    hpi_bus_controller dut_a (
        .Clk(Clk), .Reset(Reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(a_ack), .rdata_o(a_rdata), .busy_o(a_busy), .hpi_cs_n(a_cs_n), .hpi_r_n(a_r_n),
        .hpi_w_n(a_w_n), .hpi_addr(a_addr), .hpi_dout(a_dout), .hpi_dout_en(a_en), .hpi_din(hpi_din)
    );

    hpi_bus_controller #(.FIXED_PRIO(1)) dut_b (
        .Clk(Clk), .Reset(Reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(b_ack), .rdata_o(b_rdata), .busy_o(b_busy), .hpi_cs_n(b_cs_n), .hpi_r_n(b_r_n),
        .hpi_w_n(b_w_n), .hpi_addr(b_addr), .hpi_dout(b_dout), .hpi_dout_en(b_en), .hpi_din(hpi_din)
    );

    hpi_bus_controller #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3)) dut_c (
        .Clk(Clk), .Reset(Reset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(c_ack), .rdata_o(c_rdata), .busy_o(c_busy), .hpi_cs_n(c_cs_n), .hpi_r_n(c_r_n),
        .hpi_w_n(c_w_n), .hpi_addr(c_addr), .hpi_dout(c_dout), .hpi_dout_en(c_en), .hpi_din(hpi_din)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (a_bus !== 7'b0111000 || a_addr !== 2'b00 || a_dout !== 16'h0 || a_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_a got bus=%b addr=%h dout=%h rdata=%h want bus=0111000 all zero", a_bus, a_addr, a_dout, a_rdata);
        end
        vectors++;
        if (b_bus !== 7'b0111000 || c_bus !== 7'b0111000) begin
            errors++;
            $display("FAIL reset_bc got b=%b c=%b want 0111000", b_bus, c_bus);
        end
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        logic [6:0] ea, ec;
        req_i = 2'b01; we_i = 2'b01; addr_i = {2'b00, HPI_ADDR}; wdata_i = {16'h0000, 16'h1234};
        for (int k = 1; k <= 8; k++) begin
            tick();
            ea = {k <= 7, !(k <= 6), 1'b1, !(k >= 2 && k <= 5), k <= 6, (k == 7) ? 2'b01 : 2'b00};
            ec = {k <= 7, !(k <= 6), 1'b1, !(k == 3), k <= 6, (k == 7) ? 2'b01 : 2'b00};
            vectors++;
            if (a_bus !== ea || b_bus !== ea) begin
                errors++;
                $display("FAIL write_bus_ab cycle %0d got a=%b b=%b want %b", k, a_bus, b_bus, ea);
            end
            vectors++;
            if (c_bus !== ec) begin
                errors++;
                $display("FAIL write_bus_c cycle %0d got %b want %b", k, c_bus, ec);
            end
            if (k <= 6) begin
                vectors++;
                if ({a_addr, a_dout} !== {HPI_ADDR, 16'h1234} || {c_addr, c_dout} !== {HPI_ADDR, 16'h1234}) begin
                    errors++;
                    $display("FAIL write_data cycle %0d got a=%h/%h c=%h/%h want 2/1234", k, a_addr, a_dout, c_addr, c_dout);
                end
            end
            if (k == 7) req_i = 2'b00;
        end
    endtask

    task automatic test_single_read();
        logic [6:0] ea, ec;
        req_i = 2'b10; we_i = 2'b00; addr_i = {HPI_DATA, 2'b11}; wdata_i = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) hpi_din = 16'hBEEF;
            if (k == 6) hpi_din = 16'h0000;
            ea = {k <= 7, !(k <= 6), !(k >= 2 && k <= 5), 1'b1, 1'b0, (k == 7) ? 2'b10 : 2'b00};
            ec = {k <= 7, !(k <= 6), !(k == 3), 1'b1, 1'b0, (k == 7) ? 2'b10 : 2'b00};
            vectors++;
            if (a_bus !== ea || b_bus !== ea) begin
                errors++;
                $display("FAIL read_bus_ab cycle %0d got a=%b b=%b want %b", k, a_bus, b_bus, ea);
            end
            vectors++;
            if (c_bus !== ec) begin
                errors++;
                $display("FAIL read_bus_c cycle %0d got %b want %b", k, c_bus, ec);
            end
            if (k == 1) begin
                vectors++;
                if (a_addr !== HPI_DATA) begin
                    errors++;
                    $display("FAIL read_addr got %h want %h", a_addr, HPI_DATA);
                end
            end
            if (k == 7) begin
                vectors++;
                if (a_rdata !== 16'hBEEF || b_rdata !== 16'hBEEF || c_rdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL read_data got a=%h b=%h c=%h want beef", a_rdata, b_rdata, c_rdata);
                end
                req_i = 2'b00;
            end
        end
    endtask

    task automatic test_field_stability();
        req_i = 2'b01; we_i = 2'b01; addr_i = {2'b00, HPI_MAILBOX}; wdata_i = {16'h0000, 16'h1234};
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                wdata_i = {16'h0000, 16'hFFFF};
                addr_i  = {2'b00, HPI_STATUS};
                we_i    = 2'b00;
            end
            if (k == 2) req_i = 2'b00;
            if (k <= 6) begin
                vectors++;
                if ({a_addr, a_dout, a_en} !== {HPI_MAILBOX, 16'h1234, 1'b1} ||
                    {c_addr, c_dout, c_en} !== {HPI_MAILBOX, 16'h1234, 1'b1}) begin
                    errors++;
                    $display("FAIL stable_fields cycle %0d got a=%h/%h/%b c=%h/%h/%b want 1/1234/1", k, a_addr, a_dout, a_en, c_addr, c_dout, c_en);
                end
            end
            if (k == 3) begin
                vectors++;
                if (a_w_n !== 1'b0 || a_r_n !== 1'b1 || c_w_n !== 1'b0) begin
                    errors++;
                    $display("FAIL stable_strobe got a_w_n=%b a_r_n=%b c_w_n=%b want 0 1 0", a_w_n, a_r_n, c_w_n);
                end
            end
            if (k == 7) begin
                vectors++;
                if (a_ack !== 2'b01 || c_ack !== 2'b01) begin
                    errors++;
                    $display("FAIL dropped_req_ack got a=%b c=%b want 01", a_ack, c_ack);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_a;
        logic [15:0] exp_dout;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req_i = 2'b11; we_i = 2'b11; addr_i = {HPI_STATUS, HPI_DATA}; wdata_i = {16'hAAAA, 16'h5555};
        for (int acc = 0; acc < 4; acc++) begin
            exp_a    = (acc % 2 == 0) ? 2'b01 : 2'b10;
            exp_dout = (acc % 2 == 0) ? 16'h5555 : 16'hAAAA;
            for (int k = 1; k <= 8; k++) begin
                tick();
                if (k == 1) begin
                    vectors++;
                    if (a_dout !== exp_dout || b_dout !== 16'h5555 || a_cs_n !== 1'b0) begin
                        errors++;
                        $display("FAIL contend_grant acc %0d got a_dout=%h b_dout=%h cs_n=%b want %h 5555 0", acc, a_dout, b_dout, a_cs_n, exp_dout);
                    end
                end
                if (k == 7) begin
                    vectors++;
                    if (a_ack !== exp_a || c_ack !== exp_a || b_ack !== 2'b01) begin
                        errors++;
                        $display("FAIL contend_ack acc %0d got a=%b b=%b c=%b want %b 01 %b", acc, a_ack, b_ack, c_ack, exp_a, exp_a);
                    end
                    if (acc == 3) req_i = 2'b00;
                end
                if (k == 8) begin
                    vectors++;
                    if ({a_cs_n, b_cs_n, c_cs_n} !== 3'b111) begin
                        errors++;
                        $display("FAIL contend_gap acc %0d got cs_n a/b/c=%b%b%b want 111", acc, a_cs_n, b_cs_n, c_cs_n);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_strobe();
        logic [1:0] seen;
        req_i = 2'b01; we_i = 2'b01; addr_i = {2'b00, HPI_DATA}; wdata_i = {16'h0000, 16'h0BAD};
        for (int k = 1; k <= 3; k++) tick();
        vectors++;
        if (a_w_n !== 1'b0 || c_w_n !== 1'b0) begin
            errors++;
            $display("FAIL midrst_in_strobe got a_w_n=%b c_w_n=%b want 0 0", a_w_n, c_w_n);
        end
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (a_bus !== 7'b0111000 || b_bus !== 7'b0111000 || c_bus !== 7'b0111000) begin
            errors++;
            $display("FAIL midrst_async got a=%b b=%b c=%b want 0111000", a_bus, b_bus, c_bus);
        end
        req_i = 2'b00;
        tick();
        tick();
        Reset = 1'b0;
        seen = 2'b00;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | a_ack | b_ack | c_ack;
        end
        vectors++;
        if (seen !== 2'b00) begin
            errors++;
            $display("FAIL midrst_no_ack got ack %b want 00", seen);
        end
        req_i = 2'b01; we_i = 2'b01; wdata_i = {16'h0000, 16'h4321};
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (a_ack !== ((k == 7) ? 2'b01 : 2'b00) || c_ack !== ((k == 7) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL midrst_recover cycle %0d got a=%b c=%b want %b", k, a_ack, c_ack, (k == 7) ? 2'b01 : 2'b00);
            end
            if (k == 7) req_i = 2'b00;
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_field_stability();
        test_contention();
        test_reset_mid_strobe();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
